// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single write port of a register file among four requesters.
// Arbitration is round-robin. The port outputs are registered, so a request
// sampled at one rising edge appears as a write in the following cycle.
//
// Handshake (valid/ready): req_i[i] is "valid" for requester i. grant_o[i]
// is the "accepted" indication and is seen one cycle after the winning edge.
// While req_i[i] is high, addrN_i/dataN_i must not change until grant_o[i]
// has been seen high. In the cycle after that, the requester either drops
// req_i[i] or presents its next write. A requester is masked for one cycle
// after each grant. This stops a held request from being written twice and
// limits a continuously requesting master to one write every other cycle.
//
// Writes that target the top register (all ones) are still granted and
// consumed. They are not committed: RegWrite_o stays low and dropped_o
// pulses instead.
//
// Ports
//   clk_i            clock; all state changes on the rising edge
//   reset_i          synchronous, active-high reset
//   req_i[3:0]       per-requester write request
//   addr0_i..addr3_i destination register of requester 0..3
//   data0_i..data3_i write data of requester 0..3
//   grant_o[3:0]     one-hot (or zero) grant for the write issued this cycle
//   RegWrite_o       register-file write enable
//   WriteRegister_o  register-file write address
//   WriteData_o      register-file write data
//   dropped_o        granted write targeted the top register and was discarded
//   dbg_ptr_o        current round-robin priority pointer (debug visibility)
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int WIDTH = 64,
    parameter int ADDR  = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [3:0]       req_i,
    input  logic [ADDR-1:0]  addr0_i,
    input  logic [ADDR-1:0]  addr1_i,
    input  logic [ADDR-1:0]  addr2_i,
    input  logic [ADDR-1:0]  addr3_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [WIDTH-1:0] data3_i,
    output logic [3:0]       grant_o,
    output logic             RegWrite_o,
    output logic [ADDR-1:0]  WriteRegister_o,
    output logic [WIDTH-1:0] WriteData_o,
    output logic             dropped_o,
    output logic [1:0]       dbg_ptr_o
);

    // Address of the register that is never written.
    localparam logic [ADDR-1:0] DROP_ADDR = '1;

    logic [1:0]       ptr_q,      ptr_d;
    logic [3:0]       grant_q,    grant_d;
    logic             regwrite_q, regwrite_d;
    logic             dropped_q,  dropped_d;
    logic [ADDR-1:0]  wreg_q,     wreg_d;
    logic [WIDTH-1:0] wdata_q,    wdata_d;

    logic [ADDR-1:0]  addr_sel [4];
    logic [WIDTH-1:0] data_sel [4];
    logic [3:0]       eligible;
    logic             found;
    logic [1:0]       win;
    logic [1:0]       idx;

    assign addr_sel[0] = addr0_i;
    assign addr_sel[1] = addr1_i;
    assign addr_sel[2] = addr2_i;
    assign addr_sel[3] = addr3_i;
    assign data_sel[0] = data0_i;
    assign data_sel[1] = data1_i;
    assign data_sel[2] = data2_i;
    assign data_sel[3] = data3_i;

    // Winner selection. Requesters are scanned from ptr upward, with mod-4
    // wraparound coming from the 2-bit add. The requester that holds the
    // current grant is masked for this cycle.
    always_comb begin
        eligible = req_i & ~grant_q;
        found    = 1'b0;
        win      = ptr_q;
        idx      = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state and next-output logic. With no winner, the port is idle and
    // ptr holds its value.
    always_comb begin
        ptr_d      = ptr_q;
        grant_d    = 4'b0000;
        regwrite_d = 1'b0;
        dropped_d  = 1'b0;
        wreg_d     = '0;
        wdata_d    = '0;
        if (found) begin
            ptr_d      = win + 2'd1;
            grant_d    = 4'b0001 << win;
            wreg_d     = addr_sel[win];
            wdata_d    = data_sel[win];
            regwrite_d = (addr_sel[win] != DROP_ADDR);
            dropped_d  = (addr_sel[win] == DROP_ADDR);
        end
    end

    // Reset overrides arbitration. A grant won at a reset edge is lost, and
    // the requester must retry.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q      <= 2'd0;
            grant_q    <= 4'b0000;
            regwrite_q <= 1'b0;
            dropped_q  <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            regwrite_q <= regwrite_d;
            dropped_q  <= dropped_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    assign grant_o         = grant_q;
    assign RegWrite_o      = regwrite_q;
    assign WriteRegister_o = wreg_q;
    assign WriteData_o     = wdata_q;
    assign dropped_o       = dropped_q;
    assign dbg_ptr_o       = ptr_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  localparam int W = 64;
  localparam int A = 5;
  localparam logic [A-1:0] TOP = 5'd31;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]   req = 4'b0000;
  logic [A-1:0] addr_v [4];
  logic [W-1:0] data_v [4];

  logic [3:0]   grant_o;
  logic         RegWrite_o;
  logic [A-1:0] WriteRegister_o;
  logic [W-1:0] WriteData_o;
  logic         dropped_o;
  logic [1:0]   dbg_ptr_o;

  regfile_write_arbiter #(.WIDTH(W), .ADDR(A)) dut (
    .clk_i(clk), .reset_i(rst), .req_i(req),
    .addr0_i(addr_v[0]), .addr1_i(addr_v[1]), .addr2_i(addr_v[2]), .addr3_i(addr_v[3]),
    .data0_i(data_v[0]), .data1_i(data_v[1]), .data2_i(data_v[2]), .data3_i(data_v[3]),
    .grant_o(grant_o), .RegWrite_o(RegWrite_o), .WriteRegister_o(WriteRegister_o),
    .WriteData_o(WriteData_o), .dropped_o(dropped_o), .dbg_ptr_o(dbg_ptr_o)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Behavioural view: a priority pointer plus "who was granted last cycle".
  int m_ptr  = 0;
  int m_last = -1;
  logic [3:0]   e_grant;
  logic         e_rw, e_drop;
  logic [A-1:0] e_wr;
  logic [W-1:0] e_wd;

  task automatic predict();
    int win;
    int i;
    win = -1;
    e_grant = 4'b0; e_rw = 1'b0; e_drop = 1'b0; e_wr = '0; e_wd = '0;
    if (rst) begin
      m_ptr = 0;
      m_last = -1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        i = (m_ptr + k) % 4;
        if (win < 0 && req[i] && i != m_last) win = i;
      end
      if (win < 0) begin
        m_last = -1;
      end else begin
        e_grant = 4'(1 << win);
        e_wr    = addr_v[win];
        e_wd    = data_v[win];
        e_rw    = (addr_v[win] != TOP);
        e_drop  = (addr_v[win] == TOP);
        m_ptr   = (win + 1) % 4;
        m_last  = win;
      end
    end
  endtask

  // One clock: predict from current inputs, take the edge, compare just after.
  task automatic step();
    predict();
    @(posedge clk);
    #1;
    check_val("grant",   64'(grant_o),         64'(e_grant));
    check_val("regwr",   64'(RegWrite_o),      64'(e_rw));
    check_val("wreg",    64'(WriteRegister_o), 64'(e_wr));
    check_val("wdata",   WriteData_o,          e_wd);
    check_val("dropped", 64'(dropped_o),       64'(e_drop));
    check_val("ptr",     64'(dbg_ptr_o),       64'(m_ptr));
    check_val("onehot",  64'($countones(grant_o) <= 1), 64'd1);
    if (RegWrite_o) check_val("rw_onehot", 64'($countones(grant_o)), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard for stress ----------------
  logic [A+W+1:0] exp_q[$];
  logic act [4];
  int   waitc [4];

  task automatic start_write(input int i);
    addr_v[i] = ($urandom_range(0, 7) == 0) ? TOP : A'($urandom_range(0, 30));
    data_v[i] = {$urandom, $urandom};
    act[i]    = 1'b1;
    waitc[i]  = 0;
    exp_q.push_back({2'(i), addr_v[i], data_v[i]});
  endtask

  task automatic retire(input int i);
    logic [A+W+1:0] ent;
    int hit;
    ent = {2'(i), WriteRegister_o, WriteData_o};
    hit = -1;
    foreach (exp_q[j]) if (hit < 0 && exp_q[j] === ent) hit = j;
    check_val("sb_match", 64'(hit >= 0), 64'd1);
    if (hit >= 0) exp_q.delete(hit);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 4; i++) begin
      addr_v[i] = '0; data_v[i] = '0; act[i] = 1'b0; waitc[i] = 0;
    end

    // Reset state
    do_reset();
    check_val("rst_grant", 64'(grant_o), 64'd0);
    check_val("rst_ptr",   64'(dbg_ptr_o), 64'd0);

    // Single requester
    req = 4'b0010; addr_v[1] = 5'd5; data_v[1] = 64'hAB;
    step();
    check_val("single_grant", 64'(grant_o), 64'b0010);
    check_val("single_rw",    64'(RegWrite_o), 64'd1);
    check_val("single_wr",    64'(WriteRegister_o), 64'd5);
    check_val("single_wd",    WriteData_o, 64'hAB);
    req = 4'b0000;
    step();
    check_val("single_idle", 64'(grant_o), 64'd0);
    check_val("single_ptr",  64'(dbg_ptr_o), 64'd2);

    // All requesting from ptr 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      addr_v[i] = A'(i + 1);
      data_v[i] = 64'h1000 + 64'(i);
    end
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      check_val("rr_grant", 64'(grant_o), 64'(1 << (k % 4)));
      check_val("rr_wd",    WriteData_o, 64'h1000 + 64'(k % 4));
    end

    // Back-to-back single requester
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step();
      check_val("b2b_grant", 64'(grant_o), (k % 2 == 0) ? 64'd1 : 64'd0);
    end

    // Write to the top register is dropped
    do_reset();
    req = 4'b0100; addr_v[2] = TOP; data_v[2] = 64'h55;
    step();
    check_val("drop_grant", 64'(grant_o), 64'b0100);
    check_val("drop_rw",    64'(RegWrite_o), 64'd0);
    check_val("drop_flag",  64'(dropped_o), 64'd1);
    req = 4'b0000;
    step();
    check_val("drop_ptr",   64'(dbg_ptr_o), 64'd3);
    check_val("drop_pulse", 64'(dropped_o), 64'd0);

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 4; i++) addr_v[i] = A'(i + 1);
    req = 4'b1111;
    step();
    step();
    rst = 1'b1;
    step();
    check_val("midrst_grant", 64'(grant_o), 64'd0);
    check_val("midrst_rw",    64'(RegWrite_o), 64'd0);
    check_val("midrst_wd",    WriteData_o, 64'd0);
    rst = 1'b0;
    step();
    check_val("midrst_first", 64'(grant_o), 64'b0001);

    // Random stress with holding-requester protocol
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!act[i] && $urandom_range(0, 3) != 0) start_write(i);
        if (!act[i]) begin
          // Idle requesters drive junk that must not reach the port.
          addr_v[i] = A'($urandom);
          data_v[i] = {$urandom, $urandom};
        end
        req[i] = act[i];
      end
      step();
      for (int i = 0; i < 4; i++) begin
        if (grant_o[i]) begin
          check_val("sb_active", 64'(act[i]), 64'd1);
          retire(i);
        end
        if (act[i]) begin
          waitc[i]++;
          if (grant_o[i]) begin
            check_val("fair_bound", 64'(waitc[i] <= 4), 64'd1);
            act[i] = 1'b0;
          end else begin
            check_val("fair_wait", 64'(waitc[i] >= 4), 64'd0);
          end
        end
      end
    end

    // Every outstanding scoreboard entry must belong to a still-active requester.
    begin
      int n_act;
      n_act = 0;
      for (int i = 0; i < 4; i++) if (act[i]) n_act++;
      check_val("sb_left", 64'(exp_q.size()), 64'(n_act));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
